// File: rtl/mult_reservation_station.sv
// Multiplier reservation station: parks ops until CDB supplies operands, issues via a one-slot valid/ready register.
// Defining MULT_RSV_OCCUPANCY_EN adds o_occupancy, a registered count of busy entries.
module mult_reservation_station #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 2,
  parameter int N_ENTRY           = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_iq_valid,
  output logic                           i_iq_ready,
  input  logic [BW_TAG-1:0]              i_iq_tag,
  input  logic [2*BW_PROCESSOR_DATA-1:0] i_iq_V_flatten,
  input  logic [2*BW_TAG-1:0]            i_iq_Q_flatten,
  input  logic [1:0]                     i_iq_wait,
  input  logic                           i_cdb_valid,
  input  logic [BW_TAG-1:0]              i_cdb_tag,
  input  logic [BW_PROCESSOR_DATA-1:0]   i_cdb_wdata,
  output logic                           o_rsv_valid,
  input  logic                           o_rsv_ready,
  output logic [BW_TAG-1:0]              o_rsv_tag,
  output logic [2*BW_PROCESSOR_DATA-1:0] o_rsv_V_flatten
`ifdef MULT_RSV_OCCUPANCY_EN
  ,
  output logic [$clog2(N_ENTRY+1)-1:0]   o_occupancy
`endif
);
  localparam int DW = BW_PROCESSOR_DATA;
  localparam int IW = $clog2(N_ENTRY);

  logic [N_ENTRY-1:0] busy;
  logic [BW_TAG-1:0]  ent_tag  [N_ENTRY];
  logic [DW-1:0]      ent_v    [N_ENTRY][2];
  logic [BW_TAG-1:0]  ent_q    [N_ENTRY][2];
  logic [1:0]         ent_wait [N_ENTRY];

  logic [IW-1:0]     alloc_idx;
  logic [IW-1:0]     issue_idx;
  logic              issue_found;
  logic              dispatch;
  logic              load_out;
  logic [DW-1:0]     in_v [2];
  logic [BW_TAG-1:0] in_q [2];
  logic [1:0]        in_cap;

  // Ready comes only from registered busy bits, so a slot freed this cycle is visible next cycle.
  assign i_iq_ready = ~&busy;
  assign dispatch   = i_iq_valid && i_iq_ready;
  assign load_out   = (!o_rsv_valid || o_rsv_ready) && issue_found;

  always_comb begin
    alloc_idx   = '0;
    issue_idx   = '0;
    issue_found = 1'b0;
    for (int e = N_ENTRY - 1; e >= 0; e--) begin
      if (!busy[e]) alloc_idx = IW'(e);
      if (busy[e] && ent_wait[e] == 2'b00) begin
        issue_idx   = IW'(e);
        issue_found = 1'b1;
      end
    end
  end

  always_comb begin
    in_cap = '0;
    for (int i = 0; i < 2; i++) begin
      in_v[i]   = i_iq_V_flatten[i*DW +: DW];
      in_q[i]   = i_iq_Q_flatten[i*BW_TAG +: BW_TAG];
      in_cap[i] = i_iq_wait[i] && i_cdb_valid && (i_cdb_tag == in_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int e = 0; e < N_ENTRY; e++) begin
        ent_tag[e]  <= '0;
        ent_wait[e] <= '0;
        for (int i = 0; i < 2; i++) begin
          ent_v[e][i] <= '0;
          ent_q[e][i] <= '0;
        end
      end
    end else begin
      for (int e = 0; e < N_ENTRY; e++) begin
        if (dispatch && alloc_idx == IW'(e)) begin
          busy[e]    <= 1'b1;
          ent_tag[e] <= i_iq_tag;
          for (int i = 0; i < 2; i++) begin
            ent_q[e][i]    <= in_q[i];
            ent_v[e][i]    <= in_cap[i] ? i_cdb_wdata : in_v[i];
            ent_wait[e][i] <= i_iq_wait[i] && !in_cap[i];
          end
        end else if (busy[e]) begin
          for (int i = 0; i < 2; i++) begin
            if (ent_wait[e][i] && i_cdb_valid && ent_q[e][i] == i_cdb_tag) begin
              ent_v[e][i]    <= i_cdb_wdata;
              ent_wait[e][i] <= 1'b0;
            end
          end
          if (load_out && issue_idx == IW'(e)) busy[e] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rsv_valid     <= 1'b0;
      o_rsv_tag       <= '0;
      o_rsv_V_flatten <= '0;
    end else if (load_out) begin
      o_rsv_valid     <= 1'b1;
      o_rsv_tag       <= ent_tag[issue_idx];
      o_rsv_V_flatten <= {ent_v[issue_idx][1], ent_v[issue_idx][0]};
    end else if (o_rsv_ready) begin
      o_rsv_valid <= 1'b0;
    end
  end

`ifdef MULT_RSV_OCCUPANCY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_occupancy <= '0;
    end else begin
      case ({dispatch, load_out})
        2'b10:   o_occupancy <= o_occupancy + 1'b1;
        2'b01:   o_occupancy <= o_occupancy - 1'b1;
        default: o_occupancy <= o_occupancy;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mult_reservation_station.sv
// Self-checking bench for mult_reservation_station; a negedge monitor scores issued ops against a queue.
module tb_mult_reservation_station;
  localparam int D = 32;
  localparam int T = 2;
  localparam int N = 4;

  typedef struct packed {
    logic [T-1:0]   tag;
    logic [2*D-1:0] v;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           i_iq_valid = 1'b0;
  logic           i_iq_ready;
  logic [T-1:0]   i_iq_tag = '0;
  logic [2*D-1:0] i_iq_V_flatten = '0;
  logic [2*T-1:0] i_iq_Q_flatten = '0;
  logic [1:0]     i_iq_wait = '0;
  logic           i_cdb_valid = 1'b0;
  logic [T-1:0]   i_cdb_tag = '0;
  logic [D-1:0]   i_cdb_wdata = '0;
  logic           o_rsv_valid;
  logic           o_rsv_ready = 1'b0;
  logic [T-1:0]   o_rsv_tag;
  logic [2*D-1:0] o_rsv_V_flatten;
`ifdef MULT_RSV_OCCUPANCY_EN
  logic [$clog2(N+1)-1:0] o_occupancy;
`endif

  mult_reservation_station #(.BW_PROCESSOR_DATA(D), .BW_TAG(T), .N_ENTRY(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_iq_valid(i_iq_valid), .i_iq_ready(i_iq_ready), .i_iq_tag(i_iq_tag),
    .i_iq_V_flatten(i_iq_V_flatten), .i_iq_Q_flatten(i_iq_Q_flatten), .i_iq_wait(i_iq_wait),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_wdata(i_cdb_wdata),
    .o_rsv_valid(o_rsv_valid), .o_rsv_ready(o_rsv_ready), .o_rsv_tag(o_rsv_tag),
    .o_rsv_V_flatten(o_rsv_V_flatten)
`ifdef MULT_RSV_OCCUPANCY_EN
    , .o_occupancy(o_occupancy)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   issue_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pops on every handshake seen at the negedge and enforces hold-stable under backpressure.
  logic           prev_stall = 1'b0;
  logic [T-1:0]   prev_tag;
  logic [2*D-1:0] prev_v;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (o_rsv_valid !== 1'b1 || o_rsv_tag !== prev_tag || o_rsv_V_flatten !== prev_v) begin
          errors++;
          $display("FAIL hold_stable: got v=%b tag=%0d V=%h, held tag=%0d V=%h",
                   o_rsv_valid, o_rsv_tag, o_rsv_V_flatten, prev_tag, prev_v);
        end
      end
      if (o_rsv_valid && o_rsv_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: tag=%0d V=%h at cycle %0d, expected none",
                   o_rsv_tag, o_rsv_V_flatten, cyc);
        end else begin
          e = exp_q.pop_front();
          if (o_rsv_tag !== e.tag || o_rsv_V_flatten !== e.v) begin
            errors++;
            $display("FAIL issue_data: got tag=%0d V=%h, expected tag=%0d V=%h",
                     o_rsv_tag, o_rsv_V_flatten, e.tag, e.v);
          end
        end
        issue_cyc_q.push_back(cyc);
      end
      prev_stall = o_rsv_valid && !o_rsv_ready;
      prev_tag   = o_rsv_tag;
      prev_v     = o_rsv_V_flatten;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [T-1:0] tag, input logic [D-1:0] v1, input logic [D-1:0] v0,
                          input logic [T-1:0] q1, input logic [T-1:0] q0, input logic [1:0] w,
                          input logic push, input logic [D-1:0] e1, input logic [D-1:0] e0,
                          output int hc);
    int b = 0;
    while (!i_iq_ready && b < 40) begin
      step(1);
      b++;
    end
    if (b == 40) begin
      checks++;
      errors++;
      $display("FAIL dispatch_timeout: i_iq_ready=%b, expected 1 within 40 cycles", i_iq_ready);
    end
    i_iq_valid     = 1'b1;
    i_iq_tag       = tag;
    i_iq_V_flatten = {v1, v0};
    i_iq_Q_flatten = {q1, q0};
    i_iq_wait      = w;
    hc = cyc;
    if (push) exp_q.push_back('{tag: tag, v: {e1, e0}});
    step(1);
    i_iq_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      step(1);
      b++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d ops left, expected 0", exp_q.size());
      exp_q.delete();
    end
    step(1);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step(2);
    checks++;
    if (o_rsv_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", o_rsv_valid); end
    checks++;
    if (o_rsv_tag !== '0) begin errors++; $display("FAIL reset_tag: got %0d, expected 0", o_rsv_tag); end
    checks++;
    if (o_rsv_V_flatten !== '0) begin errors++; $display("FAIL reset_V: got %h, expected 0", o_rsv_V_flatten); end
    checks++;
    if (i_iq_ready !== 1'b1) begin errors++; $display("FAIL reset_iq_ready: got %b, expected 1", i_iq_ready); end
`ifdef MULT_RSV_OCCUPANCY_EN
    checks++;
    if (o_occupancy !== '0) begin errors++; $display("FAIL reset_occ: got %0d, expected 0", o_occupancy); end
`endif
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_ready_dispatch();
    int hc;
    o_rsv_ready = 1'b1;
    issue_cyc_q.delete();
    dispatch(2'd1, 32'd7, 32'd6, 2'd0, 2'd0, 2'b00, 1'b1, 32'd7, 32'd6, hc);
    wait_drain();
    checks++;
    if (issue_cyc_q.size() != 1 || issue_cyc_q[0] != hc + 2) begin
      errors++;
      $display("FAIL ready_latency: %0d issues, first at cycle %0d, expected 1 at %0d",
               issue_cyc_q.size(), (issue_cyc_q.size() > 0) ? issue_cyc_q[0] : -1, hc + 2);
    end
`ifdef MULT_RSV_OCCUPANCY_EN
    checks++;
    if (o_occupancy !== '0) begin errors++; $display("FAIL ready_occ: got %0d, expected 0", o_occupancy); end
`endif
  endtask

  task automatic test_pending_operand();
    int hc;
    int bc;
    o_rsv_ready = 1'b1;
    issue_cyc_q.delete();
    dispatch(2'd2, 32'd11, 32'd0, 2'd0, 2'd3, 2'b01, 1'b1, 32'd11, 32'd5, hc);
    step(1);
    i_cdb_valid = 1'b1;
    i_cdb_tag   = 2'd3;
    i_cdb_wdata = 32'd5;
    bc = cyc;
    step(1);
    i_cdb_valid = 1'b0;
    wait_drain();
    checks++;
    if (bc != hc + 2 || issue_cyc_q.size() != 1 || issue_cyc_q[0] != bc + 2) begin
      errors++;
      $display("FAIL pending_latency: %0d issues, first at cycle %0d, expected 1 at %0d",
               issue_cyc_q.size(), (issue_cyc_q.size() > 0) ? issue_cyc_q[0] : -1, bc + 2);
    end
  endtask

  task automatic test_same_cycle_capture();
    int hc;
    o_rsv_ready = 1'b1;
    issue_cyc_q.delete();
    i_cdb_valid = 1'b1;
    i_cdb_tag   = 2'd1;
    i_cdb_wdata = 32'd9;
    dispatch(2'd3, 32'd0, 32'd0, 2'd1, 2'd1, 2'b11, 1'b1, 32'd9, 32'd9, hc);
    i_cdb_valid = 1'b0;
    wait_drain();
    checks++;
    if (issue_cyc_q.size() != 1 || issue_cyc_q[0] != hc + 2) begin
      errors++;
      $display("FAIL capture_latency: %0d issues, first at cycle %0d, expected 1 at %0d",
               issue_cyc_q.size(), (issue_cyc_q.size() > 0) ? issue_cyc_q[0] : -1, hc + 2);
    end
  endtask

  task automatic test_full_backpressure();
    int hc;
    // Op 1 moves to the output before op 3 arrives, so op 3 reuses entry 0 and drains ahead of op 2.
    int ord[5] = '{1, 3, 2, 4, 5};
    o_rsv_ready = 1'b0;
    issue_cyc_q.delete();
    for (int k = 1; k <= 5; k++)
      dispatch(T'(k), 32'(100 + k), 32'(200 + k), 2'd0, 2'd0, 2'b00, 1'b0, 32'd0, 32'd0, hc);
    checks++;
    if (i_iq_ready !== 1'b0) begin errors++; $display("FAIL full_iq_ready: got %b, expected 0", i_iq_ready); end
    checks++;
    if (o_rsv_valid !== 1'b1 || o_rsv_tag !== T'(1) || o_rsv_V_flatten !== {32'd101, 32'd201}) begin
      errors++;
      $display("FAIL full_output: got v=%b tag=%0d V=%h, expected v=1 tag=1 V=%h",
               o_rsv_valid, o_rsv_tag, o_rsv_V_flatten, {32'd101, 32'd201});
    end
`ifdef MULT_RSV_OCCUPANCY_EN
    checks++;
    if (o_occupancy !== 3'(N)) begin errors++; $display("FAIL full_occ: got %0d, expected %0d", o_occupancy, N); end
`endif
    for (int k = 0; k < 5; k++)
      exp_q.push_back('{tag: T'(ord[k]), v: {32'(100 + ord[k]), 32'(200 + ord[k])}});
    step(3);
    o_rsv_ready = 1'b1;
    checks++;
    if (i_iq_ready !== 1'b0) begin errors++; $display("FAIL still_full: got %b, expected 0", i_iq_ready); end
    step(1);
    checks++;
    if (i_iq_ready !== 1'b1) begin errors++; $display("FAIL ready_restore: got %b, expected 1", i_iq_ready); end
    wait_drain();
    checks++;
    if (issue_cyc_q.size() != 5) begin
      errors++;
      $display("FAIL drain_count: got %0d issues, expected 5", issue_cyc_q.size());
    end else begin
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (issue_cyc_q[k] != issue_cyc_q[0] + k) begin
          errors++;
          $display("FAIL drain_rate: issue %0d at cycle %0d, expected %0d", k, issue_cyc_q[k], issue_cyc_q[0] + k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int hc;
    int hc0;
    o_rsv_ready = 1'b1;
    issue_cyc_q.delete();
    hc0 = 0;
    for (int k = 0; k < 4; k++) begin
      dispatch(T'(k), 32'(300 + k), 32'(400 + k), 2'd0, 2'd0, 2'b00, 1'b1, 32'(300 + k), 32'(400 + k), hc);
      if (k == 0) hc0 = hc;
`ifdef MULT_RSV_OCCUPANCY_EN
      checks++;
      if (o_occupancy !== 3'd1) begin errors++; $display("FAIL occ_steady: got %0d, expected 1", o_occupancy); end
`endif
    end
    wait_drain();
    checks++;
    if (issue_cyc_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d issues, expected 4", issue_cyc_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (issue_cyc_q[k] != hc0 + 2 + k) begin
          errors++;
          $display("FAIL b2b_cycle: issue %0d at cycle %0d, expected %0d", k, issue_cyc_q[k], hc0 + 2 + k);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hc;
    o_rsv_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      dispatch(T'(k), 32'(500 + k), 32'(600 + k), 2'd0, 2'd0, 2'b00, 1'b0, 32'd0, 32'd0, hc);
    checks++;
    if (o_rsv_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b, expected 1", o_rsv_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_rsv_valid !== 1'b0 || o_rsv_tag !== '0 || o_rsv_V_flatten !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b tag=%0d V=%h, expected all 0", o_rsv_valid, o_rsv_tag, o_rsv_V_flatten);
    end
`ifdef MULT_RSV_OCCUPANCY_EN
    checks++;
    if (o_occupancy !== '0) begin errors++; $display("FAIL async_reset_occ: got %0d, expected 0", o_occupancy); end
`endif
    exp_q.delete();
    step(1);
    rst_n = 1'b1;
    step(1);
    checks++;
    if (i_iq_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, expected 1", i_iq_ready); end
    o_rsv_ready = 1'b1;
    step(6);
    checks++;
    if (o_rsv_valid !== 1'b0) begin errors++; $display("FAIL stale_issue: got valid=%b, expected 0", o_rsv_valid); end
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_pending_operand();
    test_same_cycle_capture();
    test_full_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
